// File: rtl/delay_line_ctrl.sv
// delay_line_ctrl
// Integer sample delay for one I/Q beamforming channel. A circular buffer
// holds the last 2^AW samples and the read pointer trails the write pointer
// by cur_delay. Each output sample is registered one cycle after its input.
//
// Build option: define DELAY_SLEW_EN to walk cur_delay one step per input
// sample toward a requested delay, so a steering update never makes the
// output jump. Without it, an accepted request loads cur_delay directly.
module delay_line_ctrl #(
  parameter int DW = 18,
  parameter int AW = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 din_valid,
  input  logic signed [DW-1:0] dinI,
  input  logic signed [DW-1:0] dinQ,
  output logic                 dout_valid,
  output logic signed [DW-1:0] doutI,
  output logic signed [DW-1:0] doutQ,
  input  logic                 cfg_valid,
  input  logic [AW-1:0]        cfg_delay,
  output logic                 cfg_ready,
  output logic [AW-1:0]        cur_delay,
  output logic                 busy
);

  localparam int DEPTH = 1 << AW;

  // Sample storage, packed as {I,Q}.
  logic [2*DW-1:0] mem [DEPTH];

  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   fill;
  logic [AW-1:0]   rd_addr;
  logic [AW-1:0]   cur_delay_d;
  logic [2*DW-1:0] rd_word;
  logic [2*DW-1:0] sample_word;

  // The read address trails the write address; the subtraction wraps
  // naturally in AW bits. For any delay > 0 it never equals wr_ptr.
  assign rd_addr = wr_ptr - cur_delay;
  assign rd_word = mem[rd_addr];

  // Select the sample to emit: bypass at zero delay, zero while the
  // addressed slot has not been written since reset, else the stored word.
  always_comb begin
    // NOTE: assigning a default first means every path drives the signal,
    // so no latch is inferred when a branch is later added or removed.
    sample_word = {dinI, dinQ};
    if (cur_delay != '0) begin
      if (fill < cur_delay) begin
        sample_word = '0;
      end else begin
        sample_word = rd_word;
      end
    end
  end

  // Buffer write on every input sample.
  // NOTE: the RAM has no reset so it maps onto block/distributed memory;
  // the fill counter hides stale contents instead of clearing them.
  always_ff @(posedge clk) begin
    if (din_valid) begin
      mem[wr_ptr] <= {dinI, dinQ};
    end
  end

  // Write pointer and saturating fill count.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state updates use non-blocking assignments so every register
    // samples values from before the edge, independent of block order.
    if (!rst_n) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (din_valid) begin
      wr_ptr <= wr_ptr + AW'(1);
      if (fill != '1) begin
        fill <= fill + AW'(1);
      end
    end
  end

  // Registered output sample; data holds when no input arrives.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_valid <= 1'b0;
      doutI      <= '0;
      doutQ      <= '0;
    end else begin
      dout_valid <= din_valid;
      if (din_valid) begin
        doutI <= sample_word[2*DW-1:DW];
        doutQ <= sample_word[DW-1:0];
      end
    end
  end

  // Applied delay register; the next value comes from the controller below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_delay <= '0;
    end else begin
      cur_delay <= cur_delay_d;
    end
  end

`ifdef DELAY_SLEW_EN

  typedef enum logic {
    IDLE = 1'b0,
    SLEW = 1'b1
  } state_t;

  state_t        state_q;
  state_t        state_d;
  logic [AW-1:0] target_q;
  logic [AW-1:0] target_d;

  // Controller state and latched target delay.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
    end
  end

  // Accept a request while idle; while slewing, move one step per input
  // sample, after that sample has been formed with the old delay.
  always_comb begin
    state_d     = state_q;
    target_d    = target_q;
    cur_delay_d = cur_delay;
    cfg_ready   = 1'b0;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          target_d = cfg_delay;
          if (cfg_delay != cur_delay) begin
            state_d = SLEW;
          end
        end
      end
      SLEW: begin
        busy = 1'b1;
        if (din_valid) begin
          if (target_q > cur_delay) begin
            cur_delay_d = cur_delay + AW'(1);
          end else begin
            cur_delay_d = cur_delay - AW'(1);
          end
          if (cur_delay_d == target_q) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`else

  // Requests are always accepted and take effect at the next edge.
  assign cfg_ready = 1'b1;
  assign busy      = 1'b0;

  // Load the requested delay directly; the same-cycle sample used the old one.
  always_comb begin
    cur_delay_d = cur_delay;
    if (cfg_valid) begin
      cur_delay_d = cfg_delay;
    end
  end

`endif

endmodule

// File: tb/tb_delay_line_ctrl.sv
// tb_delay_line_ctrl
// Directed and randomized stimulus for delay_line_ctrl, checked against a
// sample-history model: the expected output is simply the input from
// cur_delay samples ago (or zero if that sample never existed).
module tb_delay_line_ctrl;

  localparam int DW = 18;
  localparam int AW = 5;

`ifdef DELAY_SLEW_EN
  localparam bit SLEW_MODE = 1'b1;
`else
  localparam bit SLEW_MODE = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 din_valid;
  logic signed [DW-1:0] dinI;
  logic signed [DW-1:0] dinQ;
  logic                 dout_valid;
  logic signed [DW-1:0] doutI;
  logic signed [DW-1:0] doutQ;
  logic                 cfg_valid;
  logic [AW-1:0]        cfg_delay;
  logic                 cfg_ready;
  logic [AW-1:0]        cur_delay;
  logic                 busy;

  delay_line_ctrl #(.DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .dinI       (dinI),
    .dinQ       (dinQ),
    .dout_valid (dout_valid),
    .doutI      (doutI),
    .doutQ      (doutQ),
    .cfg_valid  (cfg_valid),
    .cfg_delay  (cfg_delay),
    .cfg_ready  (cfg_ready),
    .cur_delay  (cur_delay),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model state.
  logic [2*DW-1:0]      hist[$];
  int                   m_cur;
  int                   m_tgt;
  bit                   exp_v;
  logic signed [DW-1:0] exp_i;
  logic signed [DW-1:0] exp_q;

  task automatic check(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bit m_busy();
    return SLEW_MODE && (m_cur != m_tgt);
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".dout_valid"}, 36'(dout_valid), 36'(exp_v));
    check({tag, ".doutI"}, 36'(doutI), 36'(exp_i));
    check({tag, ".doutQ"}, 36'(doutQ), 36'(exp_q));
    check({tag, ".cur_delay"}, 36'(cur_delay), 36'(m_cur));
    check({tag, ".busy"}, 36'(busy), 36'(m_busy()));
    check({tag, ".cfg_ready"}, 36'(cfg_ready), 36'(!m_busy()));
  endtask

  // One clock cycle: drive inputs, advance the model, check after the edge.
  task automatic step(input string tag, input bit v, input int i, input int q,
                      input bit cv, input int cd);
    bit              was_busy;
    int              n;
    logic [2*DW-1:0] w;
    din_valid = v;
    dinI      = i[DW-1:0];
    dinQ      = q[DW-1:0];
    cfg_valid = cv;
    cfg_delay = cd[AW-1:0];
    was_busy  = m_busy();
    exp_v     = v;
    if (v) begin
      n = hist.size();
      if (m_cur == 0)      w = {dinI, dinQ};
      else if (n >= m_cur) w = hist[n - m_cur];
      else                 w = '0;
      exp_i = w[2*DW-1:DW];
      exp_q = w[DW-1:0];
      hist.push_back({dinI, dinQ});
    end
    if (SLEW_MODE) begin
      if (was_busy) begin
        if (v) m_cur += (m_tgt > m_cur) ? 1 : -1;
      end else if (cv) begin
        m_tgt = cd;
      end
    end else if (cv) begin
      m_cur = cd;
      m_tgt = cd;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asynchronous reset applied between edges; outputs must clear at once.
  task automatic do_reset(input string tag);
    din_valid = 1'b0;
    cfg_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    hist.delete();
    m_cur = 0;
    m_tgt = 0;
    exp_v = 1'b0;
    exp_i = '0;
    exp_q = '0;
    check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Feed samples until the model reports the slew is complete (bounded).
  task automatic settle(input string tag, input int base);
    for (int k = 0; k < 40 && m_busy(); k++) begin
      step(tag, 1'b1, base + k, -(base + k), 1'b0, 0);
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    din_valid = 1'b0;
    cfg_valid = 1'b0;
    dinI      = '0;
    dinQ      = '0;
    cfg_delay = '0;
    m_cur     = 0;
    m_tgt     = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Reset state, then zero-delay bypass with continuous input.
    do_reset("reset");
    for (int k = 1; k <= 40; k++) step("bypass", 1'b1, k, -k, 1'b0, 0);

    // Delay 5 from an empty buffer: leading zeros then k-5.
    do_reset("reset_d5");
    step("cfg5", 1'b0, 0, 0, 1'b1, 5);
    for (int k = 1; k <= 40; k++) step("delay5", 1'b1, k, -k, 1'b0, 0);

    // Steady delay 3, then a request for 7 presented with a sample; a
    // request for 0 during the ramp must be ignored.
    do_reset("reset_slew");
    step("cfg3", 1'b0, 0, 0, 1'b1, 3);
    settle("ramp3", 100);
    for (int k = 1; k <= 10; k++) step("steady3", 1'b1, k, -k, 1'b0, 0);
    step("cfg7", 1'b1, 11, -11, 1'b1, 7);
    step("ign0", 1'b1, 12, -12, 1'b1, 0);
    for (int k = 13; k <= 30; k++) step("ramp7", 1'b1, k, -k, 1'b0, 0);

    // Maximum delay across buffer wrap; re-requesting it is a no-op.
    do_reset("reset_d31");
    step("cfg31", 1'b0, 0, 0, 1'b1, 31);
    for (int k = 1; k <= 100; k++) step("delay31", 1'b1, k, -k, 1'b0, 0);
    step("re31", 1'b1, 101, -101, 1'b1, 31);
    step("re31_after", 1'b1, 102, -102, 1'b0, 0);

    // Reset in the middle of a 4 -> 10 slew, then bypass resumes.
    do_reset("reset_mid");
    step("cfg4", 1'b0, 0, 0, 1'b1, 4);
    settle("ramp4", 200);
    step("cfg10", 1'b0, 0, 0, 1'b1, 10);
    step("mid_a", 1'b1, 301, -301, 1'b0, 0);
    step("mid_b", 1'b1, 302, -302, 1'b0, 0);
    do_reset("reset_async");
    step("post_rst", 1'b1, 77, -77, 1'b0, 0);

    // Gapped input during a 2 -> 0 slew: steps only on valid samples.
    do_reset("reset_gap");
    step("cfg2", 1'b0, 0, 0, 1'b1, 2);
    settle("ramp2", 400);
    for (int k = 1; k <= 6; k++) step("pre_gap", 1'b1, k, -k, 1'b0, 0);
    step("cfg0", 1'b0, 0, 0, 1'b1, 0);
    for (int c = 0; c < 9; c++) step("gap", (c % 3) == 0, 500 + c, -(500 + c), 1'b0, 0);

    // Randomized traffic and requests.
    do_reset("reset_rand");
    for (int c = 0; c < 400; c++) begin
      step("rand", $urandom_range(0, 2) != 0, int'($urandom), int'($urandom),
           $urandom_range(0, 9) == 0, int'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, observed running expected finished");
    $fatal(1);
  end

endmodule
